pixel_stream_ctrl: RTL and testbench

//  Sequences a run of 8-bit RGB332 framebuffer pixels into the 18-bit display path for the SPI LCD.

---
 rtl/pixel_stream_ctrl_if.sv | 36 +++
 rtl/pixel_stream_ctrl.sv | 127 ++++++++++++
 tb/tb_pixel_stream_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_ctrl_if.sv
// Pixel stream controller bus bundle.
// Purpose: groups the run control, framebuffer pixel handshake and SPI byte
//          handshake of pixel_stream_ctrl into one interface.
// Signals:
//   START, PIX_COUNT, ABORT  run control from the frame/window controller
//   BUSY, DONE               run status back to the frame/window controller
//   PIX_DATA, PIX_VALID      RGB332 pixel from the framebuffer read port
//   PIX_READY                pixel accepted by the controller
//   SPI_DATA, SPI_VALID      byte to the SPI transmitter
//   SPI_READY                byte accepted by the SPI transmitter
// Modports: slave = controller side, master = surrounding system side.
interface pixel_stream_ctrl_if #(
  parameter int CNT_W = 17
);
  logic             START;
  logic [CNT_W-1:0] PIX_COUNT;
  logic             ABORT;
  logic             BUSY;
  logic             DONE;
  logic [7:0]       PIX_DATA;
  logic             PIX_VALID;
  logic             PIX_READY;
  logic [7:0]       SPI_DATA;
  logic             SPI_VALID;
  logic             SPI_READY;

  modport slave (
    input  START, PIX_COUNT, ABORT, PIX_DATA, PIX_VALID, SPI_READY,
    output BUSY, DONE, PIX_READY, SPI_DATA, SPI_VALID
  );

  modport master (
    output START, PIX_COUNT, ABORT, PIX_DATA, PIX_VALID, SPI_READY,
    input  BUSY, DONE, PIX_READY, SPI_DATA, SPI_VALID
  );
endinterface

// File: rtl/pixel_stream_ctrl.sv
// Pixel stream controller.
// Purpose: fetches a run of RGB332 pixels from the framebuffer, expands each
//          to RGB666 and sends it to the SPI byte transmitter as three bytes
//          (R, G, B), each 6-bit channel left-justified in the byte.
// Ports:
//   CLK    in  system clock, rising edge
//   RST_N  in  asynchronous active-low reset
//   bus    slave modport of pixel_stream_ctrl_if (control, pixel and SPI
//          handshakes)
module pixel_stream_ctrl #(
  parameter int CNT_W = 17
) (
  input  logic               CLK,
  input  logic               RST_N,
  pixel_stream_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SEND_R = 3'd2,
    SEND_G = 3'd3,
    SEND_B = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [5:0]       r6_q, r6_d, g6_q, g6_d, b6_q, b6_d;
  logic [7:0]       spi_data_q, spi_data_d;
  logic             spi_valid_q, spi_valid_d;
  logic             pix_acc;

  // 3-bit channel * 9 is the 3-bit value replicated twice (0,9,..,63).
  function automatic logic [5:0] expand3(input logic [2:0] v);
    return {v, v};
  endfunction

  // 2-bit channel * 21 is the 2-bit value replicated three times (0,21,42,63).
  function automatic logic [5:0] expand2(input logic [1:0] v);
    return {v, v, v};
  endfunction

  assign pix_acc = (state_q == FETCH) && bus.PIX_VALID;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    r6_d    = r6_q;
    g6_d    = g6_q;
    b6_d    = b6_q;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          if (bus.PIX_COUNT != '0) begin
            rem_d   = bus.PIX_COUNT;
            state_d = FETCH;
          end else begin
            state_d = FINISH;
          end
        end
      end
      FETCH: begin
        if (pix_acc) begin
          r6_d    = expand3(bus.PIX_DATA[7:5]);
          g6_d    = expand3(bus.PIX_DATA[4:2]);
          b6_d    = expand2(bus.PIX_DATA[1:0]);
          state_d = SEND_R;
        end
      end
      SEND_R: if (bus.SPI_READY) state_d = SEND_G;
      SEND_G: if (bus.SPI_READY) state_d = SEND_B;
      SEND_B: begin
        if (bus.SPI_READY) begin
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? FINISH : FETCH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition, including a START seen in IDLE.
    if (bus.ABORT) begin
      state_d = IDLE;
      rem_d   = '0;
    end

    // SPI outputs are registered from the next state so the R byte appears
    // the cycle after the pixel handshake and holds while SPI_READY is low.
    spi_valid_d = (state_d == SEND_R) || (state_d == SEND_G) || (state_d == SEND_B);
    unique case (state_d)
      SEND_R:  spi_data_d = {r6_d, 2'b00};
      SEND_G:  spi_data_d = {g6_d, 2'b00};
      SEND_B:  spi_data_d = {b6_d, 2'b00};
      default: spi_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      r6_q        <= '0;
      g6_q        <= '0;
      b6_q        <= '0;
      spi_data_q  <= 8'h00;
      spi_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      r6_q        <= r6_d;
      g6_q        <= g6_d;
      b6_q        <= b6_d;
      spi_data_q  <= spi_data_d;
      spi_valid_q <= spi_valid_d;
    end
  end

  assign bus.BUSY      = (state_q != IDLE);
  assign bus.DONE      = (state_q == FINISH);
  assign bus.PIX_READY = (state_q == FETCH);
  assign bus.SPI_DATA  = spi_data_q;
  assign bus.SPI_VALID = spi_valid_q;

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Directed testbench for pixel_stream_ctrl.
// Purpose: applies hand-computed vectors for reset, single pixel, mapping,
//          back-pressure, zero count, ignored START, abort and async reset.
// Ports: none (top-level bench).
module tb_pixel_stream_ctrl;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] pix_mem [16];
  logic [7:0] got     [64];
  logic [7:0] exp_b   [16];

  pixel_stream_ctrl_if #(.CNT_W(17)) bus ();

  pixel_stream_ctrl #(.CNT_W(17)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // Runs an already-started stream until BUSY drops or the budget expires,
  // feeding pixels from pix_mem and logging accepted SPI bytes into got.
  // A START pulse (PIX_COUNT=7) is injected at cycle poke_cyc (if >= 0).
  task automatic run_stream(input int max_cyc, input int poke_cyc,
                            output int nb, output int nd, output int nf);
    int pi;
    pi = 0; nb = 0; nd = 0; nf = 0;
    for (int c = 0; c < max_cyc; c++) begin
      bus.START = (c == poke_cyc);
      if (c == poke_cyc) bus.PIX_COUNT = 17'd7;
      if (pi < 16) bus.PIX_DATA = pix_mem[pi];
      if (bus.PIX_READY && bus.PIX_VALID) begin
        nf++;
        pi++;
      end
      if (bus.SPI_VALID && bus.SPI_READY) begin
        if (nb < 64) got[nb] = bus.SPI_DATA;
        nb++;
      end
      if (bus.DONE) nd++;
      if (!bus.BUSY) break;
      tick();
    end
    bus.START = 1'b0;
    chk("stream_timeout_busy", bus.BUSY, 0);
  endtask

  initial begin
    int nb, nd, nf;
    bus.START     = 1'b0;
    bus.PIX_COUNT = '0;
    bus.ABORT     = 1'b0;
    bus.PIX_DATA  = 8'h00;
    bus.PIX_VALID = 1'b0;
    bus.SPI_READY = 1'b0;
    for (int i = 0; i < 16; i++) pix_mem[i] = 8'h00;

    // Reset values
    tick(); tick();
    chk("rst_busy",      bus.BUSY, 0);
    chk("rst_done",      bus.DONE, 0);
    chk("rst_pix_ready", bus.PIX_READY, 0);
    chk("rst_spi_valid", bus.SPI_VALID, 0);
    chk("rst_spi_data",  bus.SPI_DATA, 8'h00);
    RST_N = 1'b1;
    tick();
    chk("idle_busy", bus.BUSY, 0);

    // Single white pixel: FC,FC,FC on consecutive cycles, then DONE
    bus.PIX_VALID = 1'b1;
    bus.SPI_READY = 1'b1;
    bus.PIX_DATA  = 8'hFF;
    bus.PIX_COUNT = 17'd1;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("single_fetch_busy", bus.BUSY, 1);
    chk("single_fetch_rdy",  bus.PIX_READY, 1);
    chk("single_fetch_sv",   bus.SPI_VALID, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_byte_valid", bus.SPI_VALID, 1);
      chk("single_byte_data",  bus.SPI_DATA, 8'hFC);
      chk("single_byte_rdy",   bus.PIX_READY, 0);
    end
    tick();
    chk("single_done",    bus.DONE, 1);
    chk("single_fin_sv",  bus.SPI_VALID, 0);
    chk("single_fin_bsy", bus.BUSY, 1);
    tick();
    chk("single_done_off", bus.DONE, 0);
    chk("single_busy_off", bus.BUSY, 0);

    // Mapping sweep: 25 -> 24,24,54 ; B6 (R5,G5,B2) -> B4,B4,A8 ; 4A -> 48,48,A8
    pix_mem[0] = 8'h25; pix_mem[1] = 8'hB6; pix_mem[2] = 8'h4A;
    exp_b[0] = 8'h24; exp_b[1] = 8'h24; exp_b[2] = 8'h54;
    exp_b[3] = 8'hB4; exp_b[4] = 8'hB4; exp_b[5] = 8'hA8;
    exp_b[6] = 8'h48; exp_b[7] = 8'h48; exp_b[8] = 8'hA8;
    bus.PIX_DATA  = pix_mem[0];
    bus.PIX_COUNT = 17'd3;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    run_stream(60, -1, nb, nd, nf);
    chk("map_nbytes", nb, 9);
    chk("map_ndone",  nd, 1);
    chk("map_nfetch", nf, 3);
    for (int i = 0; i < 9; i++) chk($sformatf("map_byte%0d", i), got[i], exp_b[i]);

    // Back-pressure during SEND_G: pixel 25 then FF
    bus.PIX_DATA  = 8'h25;
    bus.PIX_COUNT = 17'd2;
    bus.START     = 1'b1;
    tick();                              // FETCH
    bus.START = 1'b0;
    tick();                              // SEND_R
    chk("bp_r", bus.SPI_DATA, 8'h24);
    tick();                              // SEND_G
    chk("bp_g", bus.SPI_DATA, 8'h24);
    bus.SPI_READY = 1'b0;
    bus.PIX_DATA  = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", bus.SPI_VALID, 1);
      chk("bp_hold_data",  bus.SPI_DATA, 8'h24);
      chk("bp_hold_nopix", bus.PIX_READY, 0);
    end
    bus.SPI_READY = 1'b1;
    tick();
    chk("bp_b", bus.SPI_DATA, 8'h54);
    tick();
    chk("bp_fetch2", bus.PIX_READY, 1);
    tick();
    chk("bp_r2", bus.SPI_DATA, 8'hFC);
    tick(); tick(); tick();
    chk("bp_done", bus.DONE, 1);
    tick();
    chk("bp_idle", bus.BUSY, 0);

    // Zero count: DONE one cycle after START, no bytes
    bus.PIX_COUNT = 17'd0;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    chk("zero_done", bus.DONE, 1);
    chk("zero_sv",   bus.SPI_VALID, 0);
    chk("zero_rdy",  bus.PIX_READY, 0);
    tick();
    chk("zero_done_off", bus.DONE, 0);
    chk("zero_idle",     bus.BUSY, 0);

    // START during a 4-pixel run is ignored
    pix_mem[0] = 8'h25; pix_mem[1] = 8'hB6; pix_mem[2] = 8'h4A; pix_mem[3] = 8'hFF;
    exp_b[9] = 8'hFC; exp_b[10] = 8'hFC; exp_b[11] = 8'hFC;
    bus.PIX_DATA  = pix_mem[0];
    bus.PIX_COUNT = 17'd4;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    run_stream(80, 5, nb, nd, nf);
    chk("ign_nbytes", nb, 12);
    chk("ign_ndone",  nd, 1);
    chk("ign_nfetch", nf, 4);
    for (int i = 0; i < 12; i++) chk($sformatf("ign_byte%0d", i), got[i], exp_b[i]);
    tick();
    chk("ign_stay_idle", bus.BUSY, 0);

    // Abort during SEND_R of pixel 2 of 5
    bus.PIX_DATA  = 8'h25;
    bus.PIX_COUNT = 17'd5;
    bus.START     = 1'b1;
    tick();                              // FETCH p1
    bus.START = 1'b0;
    tick(); tick(); tick();              // SEND_R, SEND_G, SEND_B
    bus.PIX_DATA = 8'hB6;
    tick();                              // FETCH p2
    tick();                              // SEND_R p2
    chk("abt_pre_sv",   bus.SPI_VALID, 1);
    chk("abt_pre_data", bus.SPI_DATA, 8'hB4);
    bus.ABORT = 1'b1;
    tick();
    bus.ABORT = 1'b0;
    chk("abt_busy", bus.BUSY, 0);
    chk("abt_sv",   bus.SPI_VALID, 0);
    chk("abt_rdy",  bus.PIX_READY, 0);
    chk("abt_done", bus.DONE, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abt_quiet_done", bus.DONE, 0);
      chk("abt_quiet_sv",   bus.SPI_VALID, 0);
    end
    pix_mem[0] = 8'h4A; pix_mem[1] = 8'h25;
    exp_b[0] = 8'h48; exp_b[1] = 8'h48; exp_b[2] = 8'hA8;
    exp_b[3] = 8'h24; exp_b[4] = 8'h24; exp_b[5] = 8'h54;
    bus.PIX_DATA  = pix_mem[0];
    bus.PIX_COUNT = 17'd2;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    run_stream(40, -1, nb, nd, nf);
    chk("abt_re_nbytes", nb, 6);
    chk("abt_re_ndone",  nd, 1);
    for (int i = 0; i < 6; i++) chk($sformatf("abt_re_byte%0d", i), got[i], exp_b[i]);

    // Async reset in the middle of SEND_G
    bus.PIX_DATA  = 8'hFF;
    bus.PIX_COUNT = 17'd3;
    bus.START     = 1'b1;
    tick();
    bus.START = 1'b0;
    tick(); tick();                      // SEND_R, SEND_G
    chk("ar_pre_sv", bus.SPI_VALID, 1);
    chk("ar_pre_bs", bus.BUSY, 1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar_sv",   bus.SPI_VALID, 0);
    chk("ar_busy", bus.BUSY, 0);
    chk("ar_done", bus.DONE, 0);
    chk("ar_data", bus.SPI_DATA, 8'h00);
    tick(); tick();
    RST_N = 1'b1;
    tick();
    chk("ar_idle_busy", bus.BUSY, 0);
    chk("ar_idle_rdy",  bus.PIX_READY, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_post_sv",   bus.SPI_VALID, 0);
      chk("ar_post_done", bus.DONE, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
